// File: rtl/fft_reorder_pingpong_if.sv
// fft_reorder_pingpong_if: input pair stream, output bin stream and framing error of the reorder stage
interface fft_reorder_pingpong_if #(parameter int WIDTH = 16, parameter int LOG2N = 3);
  logic in_valid, in_ready, in_sof;
  logic signed [WIDTH-1:0] up_real, up_imag, lo_real, lo_imag;
  logic out_valid, out_ready, out_sof, out_eof, sof_err;
  logic signed [WIDTH-1:0] out_real, out_imag;
  logic [LOG2N-1:0] out_idx;
  modport master (
    output in_valid, in_sof, up_real, up_imag, lo_real, lo_imag, out_ready,
    input in_ready, out_valid, out_real, out_imag, out_idx, out_sof, out_eof, sof_err
  );
  modport slave (
    input in_valid, in_sof, up_real, up_imag, lo_real, lo_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_idx, out_sof, out_eof, sof_err
  );
endinterface

// File: rtl/fft_reorder_pingpong.sv
// fft_reorder_pingpong: ping-pong bank reorder of bit-reversed FFT pairs into natural-order bins
module fft_reorder_pingpong #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 3,
  parameter int BITREV = 1
) (
  input logic clk,
  input logic rst,
  fft_reorder_pingpong_if.slave io
);
  localparam int N = 1 << LOG2N;
  logic [2*WIDTH-1:0] r_mem [2*N];
  logic [1:0] r_full;
  logic r_wb, r_rb;
  logic [LOG2N-2:0] r_k;
  logic [LOG2N-1:0] r_j;
  logic r_out_valid, r_out_sof, r_out_eof, r_sof_err;
  logic [WIDTH-1:0] r_out_real, r_out_imag;
  logic [LOG2N-1:0] r_out_idx;
  logic w_acc, w_wr, w_err, w_wlast, w_ld, w_rlast;
  logic [LOG2N-2:0] w_k;
  logic [LOG2N-1:0] w_a0, w_a1;
  function automatic logic [LOG2N-1:0] f_addr(input logic [LOG2N-1:0] i);
    logic [LOG2N-1:0] v;
    for (int b = 0; b < LOG2N; b++) v[b] = (BITREV != 0) ? i[LOG2N-1-b] : i[b];
    return v;
  endfunction
  // a beat with in_sof always restarts the frame at pair 0; a beat without it at pair 0 is dropped
  always_comb begin
    w_acc = io.in_valid & !r_full[r_wb];
    w_k = io.in_sof ? '0 : r_k;
    w_wr = w_acc & (io.in_sof | (r_k != '0));
    w_err = w_acc & (io.in_sof ? (r_k != '0) : (r_k == '0));
    w_wlast = w_wr & (&w_k);
    w_a0 = f_addr({w_k, 1'b0});
    w_a1 = f_addr({w_k, 1'b1});
    w_ld = r_full[r_rb] & (!r_out_valid | io.out_ready);
    w_rlast = w_ld & (&r_j);
  end
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[{r_wb, w_a0}] <= {io.up_real, io.up_imag};
      r_mem[{r_wb, w_a1}] <= {io.lo_real, io.lo_imag};
    end
  end
  // writer only touches an unfull bank and reader only a full one, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
      r_wb <= 1'b0;
      r_rb <= 1'b0;
      r_k <= '0;
      r_j <= '0;
      r_out_valid <= 1'b0;
      r_out_sof <= 1'b0;
      r_out_eof <= 1'b0;
      r_out_real <= '0;
      r_out_imag <= '0;
      r_out_idx <= '0;
      r_sof_err <= 1'b0;
    end else begin
      r_sof_err <= w_err;
      if (w_wr) r_k <= w_k + 1'b1;
      if (w_wlast) begin
        r_full[r_wb] <= 1'b1;
        r_wb <= !r_wb;
      end
      if (w_rlast) begin
        r_full[r_rb] <= 1'b0;
        r_rb <= !r_rb;
      end
      if (w_ld) begin
        {r_out_real, r_out_imag} <= r_mem[{r_rb, r_j}];
        r_out_idx <= r_j;
        r_out_sof <= r_j == '0;
        r_out_eof <= &r_j;
        r_j <= r_j + 1'b1;
      end
      r_out_valid <= w_ld | (r_out_valid & !io.out_ready);
    end
  end
  assign io.in_ready = !r_full[r_wb];
  assign io.out_valid = r_out_valid;
  assign io.out_real = r_out_real;
  assign io.out_imag = r_out_imag;
  assign io.out_idx = r_out_idx;
  assign io.out_sof = r_out_sof;
  assign io.out_eof = r_out_eof;
  assign io.sof_err = r_sof_err;
endmodule

// File: tb/tb_fft_reorder_pingpong.sv
// tb_fft_reorder_pingpong: scoreboard bench for two reorder configurations (bit-reversed N=8, natural N=16)
module tb_fft_reorder_pingpong;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_reorder_pingpong_if #(.WIDTH(16), .LOG2N(3)) a();
  fft_reorder_pingpong_if #(.WIDTH(12), .LOG2N(4)) b();
  fft_reorder_pingpong #(.WIDTH(16), .LOG2N(3), .BITREV(1)) u0 (.clk(clk), .rst(rst), .io(a));
  fft_reorder_pingpong #(.WIDTH(12), .LOG2N(4), .BITREV(0)) u1 (.clk(clk), .rst(rst), .io(b));
  typedef struct packed {int re; int im; int idx; bit sof; bit eof;} bin_t;
  typedef struct packed {int re; int im;} smp_t;
  bin_t exp_q[2][$];
  smp_t pre[2][$];
  bin_t prev[2];
  bit hold[2] = '{0, 0};
  int errs_got[2] = '{0, 0};
  int errs_exp[2] = '{0, 0};
  int n_chk = 0, n_fail = 0;
  bit saw_stall = 0;
  function automatic int brev(int v, int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r |= ((v >> i) & 1) << (bits - 1 - i);
    return r;
  endfunction
  function automatic int rnd(int w);
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction
  task automatic chk(string nm, int got, int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask
  // reference: frame = N samples in arrival order; bin j is the sample that arrived at position bitrev(j)
  task automatic acc(int id, bit sof, int ur, int ui, int lr, int li);
    int n;
    smp_t t;
    bin_t e;
    n = (id == 0) ? 8 : 16;
    if (sof) begin
      if (pre[id].size() != 0) errs_exp[id]++;
      pre[id].delete();
    end else if (pre[id].size() == 0) begin
      errs_exp[id]++;
      return;
    end
    t.re = ur; t.im = ui; pre[id].push_back(t);
    t.re = lr; t.im = li; pre[id].push_back(t);
    if (pre[id].size() == n) begin
      for (int j = 0; j < n; j++) begin
        t = pre[id][(id == 0) ? brev(j, 3) : j];
        e.re = t.re; e.im = t.im; e.idx = j; e.sof = (j == 0); e.eof = (j == n - 1);
        exp_q[id].push_back(e);
      end
      pre[id].delete();
    end
  endtask
  task automatic mon(int id, bit v, bit rdy, int re, int im, int idx, bit so, bit eo, bit err);
    bin_t g, e;
    g.re = re; g.im = im; g.idx = idx; g.sof = so; g.eof = eo;
    if (err) errs_got[id]++;
    if (hold[id]) begin
      n_chk++;
      if (!v || g != prev[id]) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%0b re=%0d im=%0d idx=%0d, required held re=%0d im=%0d idx=%0d",
                 id, v, re, im, idx, prev[id].re, prev[id].im, prev[id].idx);
      end
    end
    hold[id] = v && !rdy;
    prev[id] = g;
    if (v && rdy) begin
      n_chk++;
      if (exp_q[id].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bin[%0d]: got re=%0d idx=%0d, required no output", id, re, idx);
      end else begin
        e = exp_q[id].pop_front();
        if (g != e) begin
          n_fail++;
          $display("FAIL bin[%0d]: got re=%0d im=%0d idx=%0d sof=%0b eof=%0b, required re=%0d im=%0d idx=%0d sof=%0b eof=%0b",
                   id, re, im, idx, so, eo, e.re, e.im, e.idx, e.sof, e.eof);
        end
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      hold[0] = 0;
      hold[1] = 0;
    end else begin
      if (a.in_valid && a.in_ready)
        acc(0, a.in_sof, int'(a.up_real), int'(a.up_imag), int'(a.lo_real), int'(a.lo_imag));
      if (b.in_valid && b.in_ready)
        acc(1, b.in_sof, int'(b.up_real), int'(b.up_imag), int'(b.lo_real), int'(b.lo_imag));
      if (a.in_valid && !a.in_ready) saw_stall = 1;
      mon(0, a.out_valid, a.out_ready, int'(a.out_real), int'(a.out_imag), int'(a.out_idx), a.out_sof, a.out_eof, a.sof_err);
      mon(1, b.out_valid, b.out_ready, int'(b.out_real), int'(b.out_imag), int'(b.out_idx), b.out_sof, b.out_eof, b.sof_err);
    end
  end
  task automatic send(int id, bit sof, int ur, int ui, int lr, int li);
    int n = 0;
    if (id == 0) begin
      a.in_valid = 1; a.in_sof = sof;
      a.up_real = ur[15:0]; a.up_imag = ui[15:0]; a.lo_real = lr[15:0]; a.lo_imag = li[15:0];
    end else begin
      b.in_valid = 1; b.in_sof = sof;
      b.up_real = ur[11:0]; b.up_imag = ui[11:0]; b.lo_real = lr[11:0]; b.lo_imag = li[11:0];
    end
    forever begin
      @(negedge clk);
      if ((id == 0) ? a.in_ready : b.in_ready) break;
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout[%0d]: in_ready 0 for %0d cycles, required accept", id, n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int id);
    if (id == 0) a.in_valid = 0;
    else b.in_valid = 0;
  endtask
  task automatic frame(int id, bit gaps);
    int w = (id == 0) ? 16 : 12;
    for (int k = 0; k < ((id == 0) ? 4 : 8); k++) begin
      send(id, k == 0, rnd(w), rnd(w), rnd(w), rnd(w));
      if (gaps && $urandom_range(0, 2) == 0) begin
        idle(id);
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", exp_q[0].size() + exp_q[1].size(), 0);
    chk("sof_err_count0", errs_got[0], errs_exp[0]);
    chk("sof_err_count1", errs_got[1], errs_exp[1]);
  endtask
  initial begin
    int n;
    a.in_valid = 0; a.in_sof = 0; a.up_real = '0; a.up_imag = '0; a.lo_real = '0; a.lo_imag = '0; a.out_ready = 1;
    b.in_valid = 0; b.in_sof = 0; b.up_real = '0; b.up_imag = '0; b.lo_real = '0; b.lo_imag = '0; b.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(a.in_ready), 1);
    chk("rst_out_valid", int'(a.out_valid), 0);
    chk("rst_sof_err", int'(a.sof_err), 0);
    chk("rst_out_real", int'(a.out_real), 0);
    chk("rst_out_idx", int'(a.out_idx), 0);
    chk("rst_in_ready_b", int'(b.in_ready), 1);
    chk("rst_out_valid_b", int'(b.out_valid), 0);
    rst = 0;
    @(posedge clk);
    #1;
    // 1: known frame, bit-reversed arrival
    send(0, 1, 0, 0, 40, -40);
    send(0, 0, 20, -20, 60, -60);
    send(0, 0, 10, -10, 50, -50);
    send(0, 0, 30, -30, 70, -70);
    idle(0);
    chk("t1_valid_at_last_edge", int'(a.out_valid), 0);
    @(posedge clk);
    #1;
    chk("t1_valid_next_edge", int'(a.out_valid), 1);
    chk("t1_bin0_sof", int'(a.out_sof), 1);
    drain();
    // 2: three frames back to back
    saw_stall = 0;
    repeat (3) frame(0, 0);
    idle(0);
    chk("t2_in_ready_stall", int'(saw_stall), 1);
    drain();
    // 3: both banks full under backpressure
    a.out_ready = 0;
    repeat (2) frame(0, 0);
    idle(0);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_in_ready", int'(a.in_ready), 0);
    chk("t3_out_valid", int'(a.out_valid), 1);
    chk("t3_out_idx", int'(a.out_idx), 0);
    a.out_ready = 1;
    drain();
    // 4: restart mid-frame, then stray pair without sof
    send(0, 1, rnd(16), rnd(16), rnd(16), rnd(16));
    send(0, 0, rnd(16), rnd(16), rnd(16), rnd(16));
    send(0, 1, rnd(16), rnd(16), rnd(16), rnd(16));
    chk("t4_err_pulse", int'(a.sof_err), 1);
    send(0, 0, rnd(16), rnd(16), rnd(16), rnd(16));
    chk("t4_err_one_cycle", int'(a.sof_err), 0);
    repeat (2) send(0, 0, rnd(16), rnd(16), rnd(16), rnd(16));
    idle(0);
    repeat (12) @(posedge clk);
    #1;
    send(0, 0, rnd(16), rnd(16), rnd(16), rnd(16));
    idle(0);
    chk("t4_stray_pulse", int'(a.sof_err), 1);
    frame(0, 0);
    idle(0);
    drain();
    // 5: reset while bin 3 is held
    frame(0, 0);
    idle(0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(a.out_valid && a.out_idx == 3) && n < 50);
    a.out_ready = 0;
    chk("t5_reach_bin3", int'(a.out_idx), 3);
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("t5_async_out_valid", int'(a.out_valid), 0);
    chk("t5_async_in_ready", int'(a.in_ready), 1);
    exp_q[0].delete();
    pre[0].delete();
    @(posedge clk);
    #1;
    rst = 0;
    a.out_ready = 1;
    frame(0, 0);
    idle(0);
    drain();
    // 6: natural order, N=16, 12-bit signed extremes
    for (int k = 0; k < 8; k++)
      send(1, k == 0, (k == 0) ? -2048 : rnd(12), 2 * k, (k == 7) ? 2047 : rnd(12), 2 * k + 1);
    idle(1);
    drain();
    // 7: random input gaps and random downstream backpressure
    fork
      begin
        repeat (4) frame(0, 1);
        idle(0);
      end
      begin
        repeat (120) begin
          @(posedge clk);
          #1;
          a.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a.out_ready = 1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
